// File: rtl/move_controller.sv
// Tic-tac-toe move arbiter: validates player/computer requests against the board
// and issues one-hot write enables while tracking turn, move count and game end.
module move_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        play,
  input  logic        pc,
  input  logic [3:0]  player_position,
  input  logic [3:0]  computer_position,
  input  logic [17:0] board,
  input  logic        game_over,
  output logic [8:0]  PL_en,
  output logic [8:0]  PC_en,
  output logic        illegal_move,
  output logic        turn,
  output logic [3:0]  move_count,
  output logic        done
);

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned POS_W     = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned CELL_W    = 2;
  localparam logic [CNT_W-1:0] MAX_MOVES = CNT_W'(NUM_CELLS);

  typedef enum logic [1:0] {
    PLAYER_WAIT = 2'd0,
    COMP_WAIT   = 2'd1,
    DONE        = 2'd2
  } state_t;

  state_t state;

  logic [NUM_CELLS-1:0] cell_empty;
  logic [NUM_CELLS-1:0] player_sel;
  logic [NUM_CELLS-1:0] comp_sel;
  logic                 player_legal;
  logic                 comp_legal;
  logic [CNT_W-1:0]     count_inc;
  logic                 last_move;

  // One-hot cell decode; positions outside 1..9 decode to all zeros.
  function automatic logic [NUM_CELLS-1:0] cell_select(input logic [POS_W-1:0] pos);
    logic [NUM_CELLS-1:0] sel;
    sel = '0;
    for (int n = 0; n < NUM_CELLS; n++) begin
      if (pos == POS_W'(n + 1)) sel[n] = 1'b1;
    end
    return sel;
  endfunction

  always_comb begin
    cell_empty = '0;
    for (int n = 0; n < NUM_CELLS; n++) begin
      cell_empty[n] = (board[CELL_W*n +: CELL_W] == 2'b00);
    end
  end

  // A request is legal only when it decodes to a cell that is currently empty.
  assign player_sel   = cell_select(player_position);
  assign comp_sel     = cell_select(computer_position);
  assign player_legal = |(player_sel & cell_empty);
  assign comp_legal   = |(comp_sel & cell_empty);

  assign count_inc = (move_count >= MAX_MOVES) ? MAX_MOVES : move_count + CNT_W'(1);
  assign last_move = (count_inc == MAX_MOVES);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= PLAYER_WAIT;
      PL_en        <= '0;
      PC_en        <= '0;
      illegal_move <= 1'b0;
      turn         <= 1'b0;
      move_count   <= '0;
      done         <= 1'b0;
    end else begin
      PL_en        <= '0;
      PC_en        <= '0;
      illegal_move <= 1'b0;

      // game_over wins over any request sampled in the same cycle.
      if (game_over || state == DONE) begin
        state <= DONE;
        turn  <= 1'b0;
        done  <= 1'b1;
      end else begin
        case (state)
          PLAYER_WAIT: begin
            if (play) begin
              if (player_legal) begin
                PL_en      <= player_sel;
                move_count <= count_inc;
                if (last_move) begin
                  state <= DONE;
                  turn  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state <= COMP_WAIT;
                  turn  <= 1'b1;
                end
              end else begin
                illegal_move <= 1'b1;
              end
            end
          end
          COMP_WAIT: begin
            if (pc) begin
              if (comp_legal) begin
                PC_en      <= comp_sel;
                move_count <= count_inc;
                turn       <= 1'b0;
                if (last_move) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state <= PLAYER_WAIT;
                end
              end else begin
                illegal_move <= 1'b1;
              end
            end
          end
          default: begin
            state <= DONE;
            turn  <= 1'b0;
            done  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: a game-rules model checked every cycle,
// plus hand-computed literal expectations on key scenarios.
module tb_move_controller;

  logic        clock;
  logic        reset;
  logic        play;
  logic        pc;
  logic [3:0]  player_position;
  logic [3:0]  computer_position;
  logic [17:0] board;
  logic        game_over;
  logic [8:0]  PL_en;
  logic [8:0]  PC_en;
  logic        illegal_move;
  logic        turn;
  logic [3:0]  move_count;
  logic        done;

  int vectors;
  int miscompares;
  bit chk_en;

  // Rules model state.
  bit       m_over;
  bit       m_comp;
  int       m_count;
  logic [8:0] exp_pl;
  logic [8:0] exp_pc;
  bit       exp_ill;

  move_controller dut (
    .clock(clock),
    .reset(reset),
    .play(play),
    .pc(pc),
    .player_position(player_position),
    .computer_position(computer_position),
    .board(board),
    .game_over(game_over),
    .PL_en(PL_en),
    .PC_en(PC_en),
    .illegal_move(illegal_move),
    .turn(turn),
    .move_count(move_count),
    .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input int pos, input logic [17:0] b);
    if (pos < 1 || pos > 9) return 1'b0;
    return ((b >> (2 * (pos - 1))) & 18'h3) == 18'h0;
  endfunction

  // Game rules applied to the inputs seen at each rising edge.
  always @(posedge clock) begin
    exp_pl  = '0;
    exp_pc  = '0;
    exp_ill = 1'b0;
    if (reset) begin
      m_over  = 1'b0;
      m_comp  = 1'b0;
      m_count = 0;
    end else if (m_over) begin
      m_over = 1'b1;
    end else if (game_over) begin
      m_over = 1'b1;
    end else if (!m_comp && play) begin
      if (is_legal(int'(player_position), board)) begin
        exp_pl  = 9'(1 << (int'(player_position) - 1));
        m_count = m_count + 1;
        m_comp  = 1'b1;
        if (m_count == 9) m_over = 1'b1;
      end else begin
        exp_ill = 1'b1;
      end
    end else if (m_comp && pc) begin
      if (is_legal(int'(computer_position), board)) begin
        exp_pc  = 9'(1 << (int'(computer_position) - 1));
        m_count = m_count + 1;
        m_comp  = 1'b0;
        if (m_count == 9) m_over = 1'b1;
      end else begin
        exp_ill = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("PL_en", 32'(PL_en), 32'(exp_pl));
      chk("PC_en", 32'(PC_en), 32'(exp_pc));
      chk("illegal_move", 32'(illegal_move), 32'(exp_ill));
      chk("turn", 32'(turn), 32'(m_comp && !m_over));
      chk("move_count", 32'(move_count), 32'(m_count));
      chk("done", 32'(done), 32'(m_over));
      chk("enable_exclusive", 32'((|PL_en) && (|PC_en)), 32'(0));
    end
  end

  // One clock: drive at the falling edge, settle just after the rising edge,
  // then record accepted moves on the board.
  task automatic step(input bit r, input bit p, input logic [3:0] pp,
                      input bit c, input logic [3:0] cp, input bit go);
    @(negedge clock);
    reset             = r;
    play              = p;
    player_position   = pp;
    pc                = c;
    computer_position = cp;
    game_over         = go;
    @(posedge clock);
    #1;
    for (int n = 0; n < 9; n++) begin
      if (exp_pl[n]) board[2*n +: 2] = 2'b01;
      if (exp_pc[n]) board[2*n +: 2] = 2'b10;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    chk_en = 1'b0;
    reset = 1'b1;
    play = 1'b0;
    pc = 1'b0;
    player_position = '0;
    computer_position = '0;
    board = '0;
    game_over = 1'b0;

    step(1, 0, 4'd0, 0, 4'd0, 0);
    chk_en = 1'b1;
    step(1, 0, 4'd0, 0, 4'd0, 0);
    board = '0;
    chk("rst_count", 32'(move_count), 32'd0);
    chk("rst_turn", 32'(turn), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pl_en", 32'(PL_en), 32'd0);

    // First player move to the centre.
    step(0, 1, 4'd5, 0, 4'd0, 0);
    chk("p5_pl_en", 32'(PL_en), 32'h010);
    chk("p5_turn", 32'(turn), 32'd1);
    chk("p5_count", 32'(move_count), 32'd1);
    step(0, 0, 4'd0, 0, 4'd0, 0);
    chk("p5_pulse_end", 32'(PL_en), 32'd0);

    // Computer turn: play ignored, occupied cell rejected, then corner accepted.
    step(0, 1, 4'd2, 0, 4'd0, 0);
    chk("comp_ignores_play", 32'(PL_en), 32'd0);
    step(0, 0, 4'd0, 1, 4'd5, 0);
    chk("c5_illegal", 32'(illegal_move), 32'd1);
    chk("c5_pc_en", 32'(PC_en), 32'd0);
    chk("c5_turn", 32'(turn), 32'd1);
    step(0, 0, 4'd0, 1, 4'd1, 0);
    chk("c1_pc_en", 32'(PC_en), 32'h001);
    chk("c1_turn", 32'(turn), 32'd0);
    chk("c1_count", 32'(move_count), 32'd2);

    // Player turn: pc ignored, out-of-range and occupied positions rejected.
    step(0, 0, 4'd0, 1, 4'd2, 0);
    chk("player_ignores_pc", 32'(PC_en), 32'd0);
    step(0, 1, 4'd0, 0, 4'd0, 0);
    chk("p0_illegal", 32'(illegal_move), 32'd1);
    step(0, 1, 4'd12, 0, 4'd0, 0);
    chk("p12_illegal", 32'(illegal_move), 32'd1);
    chk("p12_count", 32'(move_count), 32'd2);
    step(0, 1, 4'd1, 0, 4'd0, 0);
    chk("p1_occupied", 32'(illegal_move), 32'd1);

    // game_over beats a legal move in the same cycle.
    step(0, 1, 4'd3, 0, 4'd0, 1);
    chk("go_pl_en", 32'(PL_en), 32'd0);
    chk("go_illegal", 32'(illegal_move), 32'd0);
    chk("go_done", 32'(done), 32'd1);
    step(0, 1, 4'd4, 0, 4'd0, 0);
    chk("done_ignores_play", 32'(PL_en), 32'd0);
    chk("done_count", 32'(move_count), 32'd2);
    step(0, 0, 4'd0, 1, 4'd4, 0);
    chk("done_ignores_pc", 32'(PC_en), 32'd0);

    // Full nine-move game.
    step(1, 0, 4'd0, 0, 4'd0, 0);
    board = '0;
    for (int i = 1; i <= 9; i++) begin
      if (i % 2 == 1) step(0, 1, 4'(i), 0, 4'd0, 0);
      else            step(0, 0, 4'd0, 1, 4'(i), 0);
    end
    chk("g9_pl_en", 32'(PL_en), 32'h100);
    chk("g9_count", 32'(move_count), 32'd9);
    chk("g9_done", 32'(done), 32'd1);
    chk("g9_turn", 32'(turn), 32'd0);
    step(0, 0, 4'd0, 1, 4'd1, 0);
    chk("g9_after_pc", 32'(PC_en), 32'd0);
    chk("g9_after_ill", 32'(illegal_move), 32'd0);

    // game_over during the computer's turn.
    step(1, 0, 4'd0, 0, 4'd0, 0);
    board = '0;
    step(0, 1, 4'd5, 0, 4'd0, 0);
    step(0, 0, 4'd0, 1, 4'd1, 1);
    chk("go_comp_pc_en", 32'(PC_en), 32'd0);
    chk("go_comp_done", 32'(done), 32'd1);
    chk("go_comp_count", 32'(move_count), 32'd1);

    // Reset mid-game with a simultaneous request.
    step(1, 0, 4'd0, 0, 4'd0, 0);
    board = '0;
    step(0, 1, 4'd5, 0, 4'd0, 0);
    step(0, 0, 4'd0, 1, 4'd1, 0);
    step(0, 1, 4'd9, 0, 4'd0, 0);
    chk("mid_count", 32'(move_count), 32'd3);
    step(1, 0, 4'd2, 1, 4'd2, 0);
    board = '0;
    chk("mid_rst_count", 32'(move_count), 32'd0);
    chk("mid_rst_turn", 32'(turn), 32'd0);
    chk("mid_rst_pc_en", 32'(PC_en), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    step(0, 0, 4'd0, 0, 4'd0, 0);
    step(0, 0, 4'd0, 0, 4'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/move_controller.md
MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 SHALL have ports: clock  input  1  rising-edge system clock.
REQ-002 SHALL have: reset  input  1  synchronous, active-high; sampled only on rising clock.
REQ-003 SHALL have: play  input  1  player move request, sampled each clock.
REQ-004 SHALL have: pc  input  1  computer move request, sampled each clock.
REQ-005 SHALL have: player_position  input  4  player target cell, 1..9 valid.
REQ-006 SHALL have: computer_position  input  4  computer target cell, 1..9 valid.
REQ-007 SHALL have: board  input  18  current cell contents; cell n at bits [2n-1:2n-2]; 00 empty, 01 player, 10 computer.
REQ-008 SHALL have: game_over  input  1  win/draw indication from the winner detector.
REQ-009 SHALL have: PL_en  output  9  one-hot player write enable; bit n-1 selects cell n.
REQ-010 SHALL have: PC_en  output  9  one-hot computer write enable; bit n-1 selects cell n.
REQ-011 SHALL have: illegal_move  output  1  one-cycle pulse on a rejected request.
REQ-012 SHALL have: turn  output  1  0 = player to move, 1 = computer to move.
REQ-013 SHALL have: move_count  output  4  accepted moves since reset, 0..9.
REQ-014 SHALL have: done  output  1  game finished; all requests ignored.

Function
REQ-015 SHALL implement FSM states PLAYER_WAIT, COMP_WAIT, DONE; all outputs registered.
REQ-016 A position SHALL be legal only if its value is 1..9 and board cell is 00; values 0 and 10..15 are illegal.
REQ-017 PLAYER_WAIT, play=1, legal: next cycle PL_en = one-hot of player_position for exactly one cycle; move_count +1; state -> COMP_WAIT.
REQ-018 PLAYER_WAIT, play=1, illegal: next cycle illegal_move=1 for one cycle, PL_en/PC_en=0, state and move_count unchanged.
REQ-019 PLAYER_WAIT SHALL ignore pc.
REQ-020 COMP_WAIT, pc=1, legal: next cycle PC_en = one-hot of computer_position for one cycle; move_count +1; state -> PLAYER_WAIT.
REQ-021 COMP_WAIT, pc=1, illegal: illegal_move pulse as REQ-018; state unchanged.
REQ-022 COMP_WAIT SHALL ignore play.
REQ-023 PL_en and PC_en SHALL never be nonzero in the same cycle; at most one bit set in each.
REQ-024 Accepted move that makes move_count reach 9 SHALL also transition to DONE (enable still issued).
REQ-025 game_over=1 in any state SHALL transition to DONE next cycle; it has priority over play/pc in the same cycle (no enable, no illegal_move).
REQ-026 DONE SHALL hold until reset; play/pc ignored, no enables, no illegal_move.
REQ-027 turn = 1 exactly in COMP_WAIT; done = 1 exactly in DONE.
REQ-028 move_count SHALL saturate at 9, never wrap.
REQ-029 Latency request-sample to enable/illegal pulse SHALL be exactly one clock.

Reset
REQ-030 reset=1 at a rising edge SHALL set state PLAYER_WAIT, PL_en=0, PC_en=0, illegal_move=0, turn=0, move_count=0, done=0.
REQ-031 reset SHALL override all other inputs in the same cycle, including mid-move pulses and DONE.

Verification
REQ-032 Reset, board=0, play=1 pos=5 -> next cycle PL_en=9'h010, turn=1, move_count=1; following cycle PL_en=0.
REQ-033 COMP_WAIT, board cell 5=01, pc=1 pos=5 -> illegal_move=1 one cycle, PC_en=0, turn stays 1; then pc=1 pos=1 -> PC_en=9'h001, turn=0, move_count=2.
REQ-034 PLAYER_WAIT, play=1 pos=0 and pos=12 -> illegal_move pulse each, move_count unchanged.
REQ-035 PLAYER_WAIT, play=1 legal pos=3 with game_over=1 same cycle -> PL_en=0, done=1 next cycle; later play ignored.
REQ-036 Nine alternating legal moves -> move_count=9, done=1 after the ninth enable pulse; reset mid-game -> all outputs to REQ-030 values next cycle.
